step_counter: RTL
=================

// Module: step_counter
// PURPOSE
//  Parametrised up/down counter advanced by a debounced push-button, all logic on one system clock.
//  Raw button sampled, synchronised, debounced and edge-detected internally; counter never clocked by a button.
//  Sits between board buttons and hex_display; count output feeds display data directly.
// PARAMETERS
//  WIDTH        16     counter width in bits (4..32)
//  DEB_CYCLES   50000  clk cycles button level must be stable to be accepted (>=2)
//  MAX_VAL      2**WIDTH-1  upper count limit; wrap/saturate point (<=2**WIDTH-1)
//  RPT_DELAY    25000000 (AUTO_REPEAT_EN only) hold cycles before first repeat
//  RPT_PERIOD   5000000  (AUTO_REPEAT_EN only) cycles between repeats
// PORTS
//  clk       in   1      system clock
//  rst_n     in   1      asynchronous active-low reset
//  btn_n     in   1      raw step button, active-low, asynchronous
//  ce        in   1      count enable; steps ignored when 0
//  clr       in   1      synchronous clear to 0 (active-high)
//  up        in   1      1 = count up, 0 = count down
//  load      in   1      synchronous load of di (active-high)
//  di        in   WIDTH  load value; values >MAX_VAL clamped to MAX_VAL
//  sat       in   1      1 = saturate at 0/MAX_VAL, 0 = wrap
//  count     out  WIDTH  current count
//  step      out  1      one-cycle pulse on each accepted step event
//  at_lim    out  1      count==MAX_VAL when up=1, count==0 when up=0 (combinational on up)
// BEHAVIOUR
//  Reset (rst_n=0, async): count=0, step=0, synchroniser FFs=1 (released), FSM=IDLE, timers=0.
//  Input path: btn_n -> 2-FF synchroniser -> debounce FSM; press = synchronised level 0.
//  FSM states: IDLE (released), PRESS_CHK, HELD, REL_CHK.
//   IDLE: level 0 -> PRESS_CHK, timer=0.
//   PRESS_CHK: level 1 -> IDLE; timer reaches DEB_CYCLES-1 -> HELD, emit step pulse.
//   HELD: level 1 -> REL_CHK, timer=0.
//   REL_CHK: level 0 -> HELD; timer reaches DEB_CYCLES-1 -> IDLE.
//  Latency: step asserts DEB_CYCLES+2 clk after btn_n falls and stays low; exactly one pulse per press.
//  Counter update on clk, priority: clr > load > (step & ce) > hold.
//   step&ce&up:   count==MAX_VAL ? (sat ? MAX_VAL : 0) : count+1.
//   step&ce&!up:  count==0 ? (sat ? 0 : MAX_VAL) : count-1.
//  step pulses regardless of ce; count changes same edge step is high (visible next cycle).
//  clr and load same cycle: clr wins. load with step same cycle: load wins, step lost.
//  Glitches shorter than DEB_CYCLES never produce step; bounce during REL_CHK extends release.
//  Reset mid-press: FSM to IDLE; button still held after reset needs full debounce -> one step.
//  up/sat changes take effect on next step; no effect on held count.
// CONFIGURATION
//  Macro STEP_COUNTER_AUTO_REPEAT_EN.
//  Defined: in HELD, repeat timer counts; at RPT_DELAY emits step, then every RPT_PERIOD while held;
//   timer cleared on leaving HELD. Repeat steps obey ce/clr/load/sat rules identically.
//  Undefined: no repeat timer logic, RPT_* unused; one step per press only.
// STRUCTURE
//  Package step_counter_pkg: FSM state encoding (IDLE, PRESS_CHK, HELD, REL_CHK, 2-bit),
//   timer width function clog2, default DEB_CYCLES constant.
//  Sub-module btn_debounce (synchroniser + FSM + timer, outputs step pulse and held level);
//   step_counter = btn_debounce + counter datapath + limit compare.
// TESTING (bench with DEB_CYCLES=8, WIDTH=4, MAX_VAL=9, RPT_DELAY=40, RPT_PERIOD=10)
//  Clean press 20 cycles, ce=1, up=1 from 0 -> one step pulse at cycle 10 after fall; count=1.
//  Bouncy press: 3 low glitches of 3 cycles then steady low -> exactly one step; release bounces -> none.
//  Wrap vs sat: count=9, up=1, sat=0 press -> 0; sat=1 press -> 9, at_lim=1; down from 0 sat=0 -> 9.
//  Priority: load=1,di=7 with clr=1 same cycle -> count=0; load di=12 -> count=9 (clamped).
//  ce=0 press -> step pulses, count unchanged; rst_n low during PRESS_CHK -> count=0, no step until re-debounced.
//  AUTO_REPEAT_EN: hold 100 cycles from 0 -> steps at ~10, 50, 60, 70, 80, 90, 100 -> count=7; undefined -> count=1.

Source files
------------

// File: rtl/step_counter_pkg.sv
// -----------------------------------------------------------------------------
// step_counter_pkg
//   Shared definitions for the step_counter block:
//     - deb_state_e     : 2-bit debounce FSM state encoding
//     - clog2()         : bit width needed to hold the values 0..value-1
//     - DEF_DEB_CYCLES  : default debounce window in clk cycles
// -----------------------------------------------------------------------------
package step_counter_pkg;

  // Debounce FSM states. IDLE is the released state and the reset state.
  typedef enum logic [1:0] {
    IDLE      = 2'b00,  // button released and stable
    PRESS_CHK = 2'b01,  // low seen, waiting for it to stay low
    HELD      = 2'b10,  // press accepted, button still down
    REL_CHK   = 2'b11   // high seen, waiting for it to stay high
  } deb_state_e;

  // Default debounce window: 1 ms at 50 MHz.
  localparam int DEF_DEB_CYCLES = 50000;

  // Bits needed to represent 0..value-1 (at least one bit).
  // Used only on elaboration-time constants.
  function automatic int clog2(input longint value);
    int w;
    w = 1;
    for (int i = 1; i < 63; i++) begin
      if ((longint'(1) << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage : step_counter_pkg

// File: rtl/step_counter_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   Turns a raw, bouncy, asynchronous active-low push-button into a one-cycle
//   step pulse on clk. The button is never used as a clock.
//
//   btn_n -> 2-FF synchroniser -> 4-state debounce FSM (+ window timer)
//
//   A press is accepted once the synchronised level has stayed low for the
//   whole debounce window; step then pulses for exactly one cycle. A release
//   must likewise stay high for the whole window before a new press can be
//   accepted, so bounce on release only lengthens the release check.
//
//   Optional feature (macro STEP_COUNTER_AUTO_REPEAT_EN): while the button
//   stays HELD, a repeat timer emits a step after RPT_DELAY cycles and then
//   every RPT_PERIOD cycles. Without the macro there is no repeat logic.
//
// Ports
//   clk    in  1  system clock
//   rst_n  in  1  asynchronous active-low reset
//   btn_n  in  1  raw button, active-low, asynchronous to clk
//   step   out 1  one-cycle pulse per accepted step event
// -----------------------------------------------------------------------------
module btn_debounce
  import step_counter_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
`ifdef STEP_COUNTER_AUTO_REPEAT_EN
  ,
  parameter int RPT_DELAY  = 25000000,
  parameter int RPT_PERIOD = 5000000
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic step
);

  localparam int            TW       = clog2(DEB_CYCLES);
  localparam logic [TW-1:0] DEB_LAST = TW'(DEB_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Synchroniser. Both flops reset to 1 so the button reads as released
  // straight out of reset, even if it is physically held.
  // ---------------------------------------------------------------------------
  logic sync_1;
  logic sync_2;
  logic pressed;

  // NOTE: sequential state is written with <= so every flop samples the
  // values from before the edge; blocking = here would turn the two-stage
  // synchroniser into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= btn_n;
      sync_2 <= sync_1;
    end
  end

  assign pressed = ~sync_2;

  // ---------------------------------------------------------------------------
  // Debounce FSM: state register
  // ---------------------------------------------------------------------------
  deb_state_e    state;
  deb_state_e    state_nxt;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;
  logic          deb_done;

  assign deb_done = (timer == DEB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM: next-state logic
  // The timer only advances while the level agrees with the state being
  // checked; any disagreement drops back to the previous stable state.
  // ---------------------------------------------------------------------------
  // NOTE: every variable driven here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    unique case (state)
      IDLE: begin
        if (pressed) begin
          state_nxt = PRESS_CHK;
          timer_nxt = '0;
        end
      end
      PRESS_CHK: begin
        if (!pressed)      state_nxt = IDLE;
        else if (deb_done) state_nxt = HELD;
        else               timer_nxt = timer + 1'b1;
      end
      HELD: begin
        if (!pressed) begin
          state_nxt = REL_CHK;
          timer_nxt = '0;
        end
      end
      REL_CHK: begin
        if (pressed)       state_nxt = HELD;
        else if (deb_done) state_nxt = IDLE;
        else               timer_nxt = timer + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef STEP_COUNTER_AUTO_REPEAT_EN
  // ---------------------------------------------------------------------------
  // Auto-repeat timer. Counts only while HELD with the button still down and
  // is cleared whenever HELD is left. rpt_armed selects the first-repeat
  // delay or the steady repeat period as the current target.
  // ---------------------------------------------------------------------------
  localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RW      = clog2(RPT_MAX);

  logic [RW-1:0] rpt_timer;
  logic [RW-1:0] rpt_timer_nxt;
  logic [RW-1:0] rpt_target;
  logic          rpt_armed;
  logic          rpt_armed_nxt;
  logic          rpt_step;

  assign rpt_target = rpt_armed ? RW'(RPT_PERIOD - 1) : RW'(RPT_DELAY - 1);

  always_comb begin
    rpt_step      = (state == HELD) && pressed && (rpt_timer == rpt_target);
    rpt_timer_nxt = '0;
    rpt_armed_nxt = 1'b0;
    if ((state == HELD) && pressed) begin
      if (rpt_step) begin
        rpt_timer_nxt = '0;
        rpt_armed_nxt = 1'b1;
      end else begin
        rpt_timer_nxt = rpt_timer + 1'b1;
        rpt_armed_nxt = rpt_armed;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_timer <= '0;
      rpt_armed <= 1'b0;
    end else begin
      rpt_timer <= rpt_timer_nxt;
      rpt_armed <= rpt_armed_nxt;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Debounce FSM: outputs
  // The press step is high in the single cycle where PRESS_CHK has seen the
  // full window low; the next edge moves to HELD, so it cannot repeat.
  // ---------------------------------------------------------------------------
  always_comb begin
    step = 1'b0;
    if ((state == PRESS_CHK) && pressed && deb_done) step = 1'b1;
`ifdef STEP_COUNTER_AUTO_REPEAT_EN
    if (rpt_step) step = 1'b1;
`endif
  end

endmodule : btn_debounce

// File: rtl/step_counter.sv
// -----------------------------------------------------------------------------
// step_counter
//   Parametrised up/down counter stepped by a debounced push-button. All
//   logic runs on clk; the raw button only feeds the debouncer. The count
//   output drives hex_display data directly.
//
//   Counter priority on each clk edge: clr > load > (step & ce) > hold.
//   Counting wraps between 0 and MAX_VAL, or saturates there when sat=1.
//   Load values above MAX_VAL are clamped to MAX_VAL.
//
//   Optional feature (macro STEP_COUNTER_AUTO_REPEAT_EN): a held button
//   auto-repeats steps (RPT_DELAY, then every RPT_PERIOD). The RPT_*
//   parameters exist only when the macro is defined.
//
// Ports
//   clk     in  1      system clock
//   rst_n   in  1      asynchronous active-low reset
//   btn_n   in  1      raw step button, active-low, asynchronous
//   ce      in  1      count enable; steps ignored when 0
//   clr     in  1      synchronous clear to 0
//   up      in  1      1 = count up, 0 = count down
//   load    in  1      synchronous load of di
//   di      in  WIDTH  load value (clamped to MAX_VAL)
//   sat     in  1      1 = saturate at 0/MAX_VAL, 0 = wrap
//   count   out WIDTH  current count
//   step    out 1      one-cycle pulse on each accepted step event
//   at_lim  out 1      count at the limit in the current direction
// -----------------------------------------------------------------------------
module step_counter
  import step_counter_pkg::*;
#(
  parameter int     WIDTH      = 16,
  parameter int     DEB_CYCLES = DEF_DEB_CYCLES,
  parameter longint MAX_VAL    = (longint'(1) << WIDTH) - 1
`ifdef STEP_COUNTER_AUTO_REPEAT_EN
  ,
  parameter int     RPT_DELAY  = 25000000,
  parameter int     RPT_PERIOD = 5000000
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_n,
  input  logic             ce,
  input  logic             clr,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] di,
  input  logic             sat,
  output logic [WIDTH-1:0] count,
  output logic             step,
  output logic             at_lim
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

  // ---------------------------------------------------------------------------
  // Button front end
  // ---------------------------------------------------------------------------
  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
`ifdef STEP_COUNTER_AUTO_REPEAT_EN
    ,
    .RPT_DELAY  (RPT_DELAY),
    .RPT_PERIOD (RPT_PERIOD)
`endif
  ) u_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_n),
    .step  (step)
  );

  // ---------------------------------------------------------------------------
  // Counter datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] di_clamped;
  logic [WIDTH-1:0] count_nxt;
  logic             at_max;
  logic             at_zero;

  assign di_clamped = (di > MAX_C) ? MAX_C : di;
  assign at_max     = (count == MAX_C);
  assign at_zero    = (count == '0);

  // A step that coincides with clr or load is dropped, not deferred.
  always_comb begin
    count_nxt = count;
    if (clr) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = di_clamped;
    end else if (step && ce) begin
      if (up) begin
        if (at_max) count_nxt = sat ? MAX_C : '0;
        else        count_nxt = count + 1'b1;
      end else begin
        if (at_zero) count_nxt = sat ? '0 : MAX_C;
        else         count_nxt = count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else        count <= count_nxt;
  end

  // Limit flag follows up combinationally so the display can react at once.
  assign at_lim = up ? at_max : at_zero;

endmodule : step_counter
